// File: rtl/pfrv_pkg.sv
// Shared pfr-v decode definitions: opcodes, immediate formats, source-use helpers.
// Latency: none (constants and pure functions).
// Backpressure: not applicable.
package pfrv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_R32    = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  // Immediate layout implied by the opcode; unknown opcodes carry no immediate.
  function automatic imm_fmt_t imm_fmt_of(input logic [6:0] op);
    imm_fmt_t f;
    case (op)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: f = IMM_I;
      OP_STORE:                           f = IMM_S;
      OP_BRANCH:                          f = IMM_B;
      OP_LUI, OP_AUIPC:                   f = IMM_U;
      OP_JAL:                             f = IMM_J;
      default:                            f = IMM_NONE;
    endcase
    return f;
  endfunction

  // rs1 field is a real source for everything except LUI/AUIPC/JAL.
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  // rs2 field is a real source only for register-register, store and branch.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R || op == OP_R32 || op == OP_STORE || op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/regfile_wb.sv
// Register file, 2 read / 1 write, x0 hardwired to zero, optional write-back bypass.
// Latency: reads combinational; write lands on the rising edge.
// Backpressure: none; writes are always accepted.
module regfile_wb #(
  parameter int N         = 64,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   i_ra1,
  input  logic [4:0]   i_ra2,
  output logic [N-1:0] o_rd1,
  output logic [N-1:0] o_rd2,
  input  logic         i_we3,
  input  logic [4:0]   i_wa3,
  input  logic [N-1:0] i_wd3
);

  localparam int AW = $clog2(NREG);

  logic [N-1:0] r_mem [NREG];
  logic         w_wr_ok;

  // Indices beyond the implemented registers behave like x0: never written, read 0.
  assign w_wr_ok = i_we3 && (i_wa3 != 5'd0) && (32'(i_wa3) < NREG);

  function automatic logic [N-1:0] read_port(input logic [4:0] a);
    logic [N-1:0] v;
    v = '0;
    if (a != 5'd0 && 32'(a) < NREG) begin
      if (WB_BYPASS != 0 && w_wr_ok && i_wa3 == a) v = i_wd3;
      else                                          v = r_mem[a[AW-1:0]];
    end
    return v;
  endfunction

  assign o_rd1 = read_port(i_ra1);
  assign o_rd2 = read_port(i_ra2);

  // Storage: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_wa3[AW-1:0]] <= i_wd3;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// pfr-v decode: register read, immediate generation, load-use hazard, ID/EX register.
// Latency: 1 cycle from D inputs to _E outputs.
// Backpressure: stall_D holds IF/ID for one cycle on load-use; flush overrides it.
module decode_stage
  import pfrv_pkg::*;
#(
  parameter int N         = 64,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         valid_D,
  input  logic [31:0]  instr_D,
  input  logic [N-1:0] pc_D,
  input  logic         flush_D,
  input  logic         regWrite_W,
  input  logic [4:0]   wa3_W,
  input  logic [N-1:0] writeData3_W,
  output logic         stall_D,
  output logic         valid_E,
  output logic [N-1:0] pc_E,
  output logic [N-1:0] readData1_E,
  output logic [N-1:0] readData2_E,
  output logic [N-1:0] signImm_E,
  output logic [4:0]   rs1_E,
  output logic [4:0]   rs2_E,
  output logic [4:0]   rd_E,
  output logic [6:0]   opcode_E,
  output logic [2:0]   funct3_E,
  output logic         funct7b5_E
);

  logic [6:0]   w_op;
  logic [4:0]   w_rs1;
  logic [4:0]   w_rs2;
  logic [4:0]   w_rd;
  imm_fmt_t     w_fmt;
  logic [31:0]  w_imm32;
  logic [N-1:0] w_imm;
  logic [N-1:0] w_rd1;
  logic [N-1:0] w_rd2;
  logic         w_hazard;
  logic         w_bubble;

  assign w_op  = instr_D[6:0];
  assign w_rs1 = instr_D[19:15];
  assign w_rs2 = instr_D[24:20];
  assign w_rd  = instr_D[11:7];
  assign w_fmt = imm_fmt_of(w_op);

  regfile_wb #(.N(N), .NREG(NREG), .WB_BYPASS(WB_BYPASS)) u_rf (
    .clk   (clk),
    .rst_n (reset_n),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we3 (regWrite_W),
    .i_wa3 (wa3_W),
    .i_wd3 (writeData3_W)
  );

  // Assemble the 32-bit immediate for the decoded format; sign lives in instr[31].
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      IMM_I:   w_imm32 = {{20{instr_D[31]}}, instr_D[31:20]};
      IMM_S:   w_imm32 = {{20{instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
      IMM_B:   w_imm32 = {{19{instr_D[31]}}, instr_D[31], instr_D[7],
                          instr_D[30:25], instr_D[11:8], 1'b0};
      IMM_U:   w_imm32 = {instr_D[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{instr_D[31]}}, instr_D[31], instr_D[19:12],
                          instr_D[20], instr_D[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm = N'($signed(w_imm32));

  // Load in E whose destination is a live source of D; only ID/EX state and D fields
  // feed this, so there is no path from the write-back port to stall_D.
  assign w_hazard = valid_E && (opcode_E == OP_LOAD) && (rd_E != 5'd0) && valid_D &&
                    ((uses_rs1(w_op) && (w_rs1 == rd_E)) ||
                     (uses_rs2(w_op) && (w_rs2 == rd_E)));

  // A flushed instruction is dead, so it never needs to hold the front end.
  assign stall_D  = w_hazard && !flush_D;
  assign w_bubble = flush_D || w_hazard || !valid_D;

  // ID/EX register: bubbles load all-zero so they can never look like a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_E     <= 1'b0;
      pc_E        <= '0;
      readData1_E <= '0;
      readData2_E <= '0;
      signImm_E   <= '0;
      rs1_E       <= '0;
      rs2_E       <= '0;
      rd_E        <= '0;
      opcode_E    <= '0;
      funct3_E    <= '0;
      funct7b5_E  <= 1'b0;
    end else if (w_bubble) begin
      valid_E     <= 1'b0;
      pc_E        <= '0;
      readData1_E <= '0;
      readData2_E <= '0;
      signImm_E   <= '0;
      rs1_E       <= '0;
      rs2_E       <= '0;
      rd_E        <= '0;
      opcode_E    <= '0;
      funct3_E    <= '0;
      funct7b5_E  <= 1'b0;
    end else begin
      valid_E     <= 1'b1;
      pc_E        <= pc_D;
      readData1_E <= w_rd1;
      readData2_E <= w_rd2;
      signImm_E   <= w_imm;
      rs1_E       <= w_rs1;
      rs2_E       <= w_rs2;
      rd_E        <= w_rd;
      opcode_E    <= w_op;
      funct3_E    <= instr_D[14:12];
      funct7b5_E  <= instr_D[30];
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus random traffic vs a model.
// Latency: model predicts _E one edge after D inputs.
// Backpressure: held instruction is re-presented while stall_D is high.
module tb_decode_stage;
  import pfrv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_D;
  logic [31:0] instr_D;
  logic [63:0] pc_D;
  logic        flush_D;
  logic        regWrite_W;
  logic [4:0]  wa3_W;
  logic [63:0] writeData3_W;

  logic        stall_D, valid_E, funct7b5_E;
  logic [63:0] pc_E, readData1_E, readData2_E, signImm_E;
  logic [4:0]  rs1_E, rs2_E, rd_E;
  logic [6:0]  opcode_E;
  logic [2:0]  funct3_E;

  logic        b_stall, b_valid, b_f7;
  logic [63:0] b_pc, b_rd1, b_rd2, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [6:0]  b_op;
  logic [2:0]  b_f3;

  always #5 clk = ~clk;

  decode_stage #(.N(64), .NREG(32), .WB_BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D),
    .flush_D(flush_D), .regWrite_W(regWrite_W), .wa3_W(wa3_W), .writeData3_W(writeData3_W),
    .stall_D(stall_D), .valid_E(valid_E), .pc_E(pc_E), .readData1_E(readData1_E),
    .readData2_E(readData2_E), .signImm_E(signImm_E), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .opcode_E(opcode_E), .funct3_E(funct3_E), .funct7b5_E(funct7b5_E)
  );

  decode_stage #(.N(64), .NREG(32), .WB_BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D),
    .flush_D(flush_D), .regWrite_W(regWrite_W), .wa3_W(wa3_W), .writeData3_W(writeData3_W),
    .stall_D(b_stall), .valid_E(b_valid), .pc_E(b_pc), .readData1_E(b_rd1),
    .readData2_E(b_rd2), .signImm_E(b_imm), .rs1_E(b_rs1), .rs2_E(b_rs2),
    .rd_E(b_rd), .opcode_E(b_op), .funct3_E(b_f3), .funct7b5_E(b_f7)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: architectural registers and the expected ID/EX contents.
  logic [63:0] rf [32];
  logic        m_valid, m_f7;
  logic [63:0] m_pc, m_rd1, m_rd2, m_rd1_nb, m_rd2_nb, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic        last_stall;
  logic [6:0]  op_tab [13];

  function automatic logic [31:0] enc_r(logic [4:0] rs2, logic [4:0] rs1, logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, OP_R};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], OP_STORE};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  // Immediate value rebuilt as a signed sum of weighted bit fields.
  function automatic logic [63:0] ref_imm(logic [31:0] ins);
    longint v;
    bit     s;
    logic [6:0] op;
    s  = ins[31];
    op = ins[6:0];
    v  = 0;
    if (op inside {OP_LOAD, OP_IMM, OP_IMM32, OP_JALR})
      v = (s ? -64'sd2048 : 0) + longint'(ins[30:20]);
    else if (op == OP_STORE)
      v = (s ? -64'sd2048 : 0) + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
    else if (op == OP_BRANCH)
      v = (s ? -64'sd4096 : 0) + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 +
          longint'(ins[11:8]) * 2;
    else if (op inside {OP_LUI, OP_AUIPC})
      v = (s ? -64'sd2147483648 : 0) + longint'(ins[30:12]) * 4096;
    else if (op == OP_JAL)
      v = (s ? -64'sd1048576 : 0) + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 +
          longint'(ins[30:21]) * 2;
    return v;
  endfunction

  function automatic bit ref_hazard();
    bit u1, u2;
    logic [6:0] op;
    op = instr_D[6:0];
    u1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    u2 = op inside {OP_R, OP_R32, OP_STORE, OP_BRANCH};
    return m_valid && m_op == OP_LOAD && m_rd != 0 && valid_D &&
           ((u1 && instr_D[19:15] == m_rd) || (u2 && instr_D[24:20] == m_rd));
  endfunction

  function automatic logic [63:0] ref_read(logic [4:0] a, bit byp);
    if (a == 0) return 64'd0;
    if (byp && regWrite_W && wa3_W == a) return writeData3_W;
    return rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    m_valid = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_rd1_nb = 0; m_rd2_nb = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0; m_f3 = 0; m_f7 = 0;
  endtask

  task automatic model_edge();
    bit bub;
    bub = flush_D || ref_hazard() || !valid_D;
    if (bub) begin
      m_valid = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_rd1_nb = 0; m_rd2_nb = 0; m_imm = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0; m_f3 = 0; m_f7 = 0;
    end else begin
      m_valid  = 1;
      m_pc     = pc_D;
      m_rd1    = ref_read(instr_D[19:15], 1);
      m_rd2    = ref_read(instr_D[24:20], 1);
      m_rd1_nb = ref_read(instr_D[19:15], 0);
      m_rd2_nb = ref_read(instr_D[24:20], 0);
      m_imm    = ref_imm(instr_D);
      m_rs1    = instr_D[19:15];
      m_rs2    = instr_D[24:20];
      m_rd     = instr_D[11:7];
      m_op     = instr_D[6:0];
      m_f3     = instr_D[14:12];
      m_f7     = instr_D[30];
    end
    if (regWrite_W && wa3_W != 0) rf[wa3_W] = writeData3_W;
  endtask

  task automatic check_e();
    chk("valid_E", 64'(valid_E), 64'(m_valid));
    chk("pc_E", pc_E, m_pc);
    chk("readData1_E", readData1_E, m_rd1);
    chk("readData2_E", readData2_E, m_rd2);
    chk("signImm_E", signImm_E, m_imm);
    chk("rs1_E", 64'(rs1_E), 64'(m_rs1));
    chk("rs2_E", 64'(rs2_E), 64'(m_rs2));
    chk("rd_E", 64'(rd_E), 64'(m_rd));
    chk("opcode_E", 64'(opcode_E), 64'(m_op));
    chk("funct3_E", 64'(funct3_E), 64'(m_f3));
    chk("funct7b5_E", 64'(funct7b5_E), 64'(m_f7));
    chk("nb_readData1_E", b_rd1, m_rd1_nb);
    chk("nb_readData2_E", b_rd2, m_rd2_nb);
    chk("nb_valid_E", 64'(b_valid), 64'(m_valid));
  endtask

  // One clock: inputs are already driven just after the previous rising edge.
  task automatic cycle();
    bit exp_stall;
    #3;
    exp_stall  = ref_hazard() && !flush_D;
    last_stall = stall_D;
    chk("stall_D", 64'(stall_D), 64'(exp_stall));
    chk("nb_stall_D", 64'(b_stall), 64'(exp_stall));
    @(posedge clk);
    model_edge();
    #1;
    check_e();
  endtask

  task automatic set_d(input logic v, input logic [31:0] ins, input logic fl);
    valid_D = v;
    instr_D = ins;
    pc_D    = {$urandom, $urandom};
    flush_D = fl;
  endtask

  task automatic set_w(input logic we, input logic [4:0] wa, input logic [63:0] wd);
    regWrite_W   = we;
    wa3_W        = wa;
    writeData3_W = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    op_tab = '{OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI,
               OP_AUIPC, OP_JAL, OP_R, OP_R32, 7'b0001111, 7'b1110011};
    reset_n = 1'b0;
    set_d(0, 32'd0, 0);
    set_w(0, 5'd0, 64'd0);
    model_reset();
    #12;
    chk("reset_valid_E", 64'(valid_E), 64'd0);
    chk("reset_pc_E", pc_E, 64'd0);
    chk("reset_stall_D", 64'(stall_D), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Same-cycle write-back reaches the read only with the bypass enabled.
    set_d(1, enc_r(5'd0, 5'd5, 5'd6), 0);
    set_w(1, 5'd5, 64'hDEAD_BEEF);
    cycle();
    chk("bypass_rd1", readData1_E, 64'hDEAD_BEEF);
    chk("nobypass_rd1", b_rd1, 64'd0);
    set_w(0, 5'd0, 64'd0);
    cycle();
    chk("nobypass_next_rd1", b_rd1, 64'hDEAD_BEEF);

    // Immediates.
    set_d(1, enc_s(12'hFFC, 5'd2, 5'd3), 0); cycle();
    chk("imm_sw", signImm_E, 64'hFFFF_FFFF_FFFF_FFFC);
    set_d(1, enc_b(13'h1FF8, 5'd0, 5'd0), 0); cycle();
    chk("imm_beq", signImm_E, 64'hFFFF_FFFF_FFFF_FFF8);
    set_d(1, 32'h8000_00B7, 0); cycle();
    chk("imm_lui", signImm_E, 64'hFFFF_FFFF_8000_0000);
    set_d(1, enc_j(21'h800, 5'd1), 0); cycle();
    chk("imm_jal", signImm_E, 64'h0000_0000_0000_0800);

    // Load-use: one stall, bubble, then the dependent add issues.
    set_d(1, enc_i(12'd0, 5'd1, 3'b011, 5'd7, OP_LOAD), 0); cycle();
    set_d(1, enc_r(5'd2, 5'd7, 5'd8), 0); cycle();
    chk("lu_stall", 64'(last_stall), 64'd1);
    chk("lu_bubble_valid", 64'(valid_E), 64'd0);
    cycle();
    chk("lu_restart_stall", 64'(last_stall), 64'd0);
    chk("lu_issue_valid", 64'(valid_E), 64'd1);
    chk("lu_issue_rd", 64'(rd_E), 64'd8);

    set_d(1, enc_i(12'd0, 5'd1, 3'b011, 5'd7, OP_LOAD), 0); cycle();
    set_d(1, enc_r(5'd2, 5'd0, 5'd8), 0); cycle();
    chk("lu_nodep_stall", 64'(last_stall), 64'd0);

    set_d(1, enc_i(12'd0, 5'd1, 3'b011, 5'd7, OP_LOAD), 0); cycle();
    set_d(1, 32'h0003_83B7, 0); cycle();
    chk("lu_lui_stall", 64'(last_stall), 64'd0);

    // Flush beats the hazard.
    set_d(1, enc_i(12'd0, 5'd1, 3'b011, 5'd7, OP_LOAD), 0); cycle();
    set_d(1, enc_r(5'd2, 5'd7, 5'd8), 1); cycle();
    chk("flush_stall", 64'(last_stall), 64'd0);
    chk("flush_valid", 64'(valid_E), 64'd0);

    // x0 is never written and a load to x0 never stalls.
    set_d(0, 32'd0, 0); set_w(1, 5'd0, 64'h1234); cycle();
    set_w(0, 5'd0, 64'd0);
    set_d(1, enc_r(5'd0, 5'd0, 5'd9), 0); cycle();
    chk("x0_read", readData1_E, 64'd0);
    set_d(1, enc_i(12'd0, 5'd1, 3'b011, 5'd0, OP_LOAD), 0); cycle();
    set_d(1, enc_r(5'd0, 5'd0, 5'd8), 0); cycle();
    chk("x0_load_stall", 64'(last_stall), 64'd0);

    // Random traffic; a stalled instruction is held in D like IF/ID would.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      if (!(last_stall && valid_D)) begin
        ins        = $urandom;
        ins[6:0]   = op_tab[$urandom_range(0, 12)];
        if ($urandom_range(0, 3) == 0) ins[6:0] = OP_LOAD;
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        set_d(1'($urandom_range(0, 7) != 0), ins, 1'($urandom_range(0, 9) == 0));
      end else begin
        flush_D = 1'($urandom_range(0, 9) == 0);
      end
      set_w(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      cycle();
    end

    // Populate registers with non-zero data and a live instruction, then reset mid-cycle.
    for (int i = 1; i < 8; i++) begin
      set_d(1, enc_r(5'(i), 5'(i), 5'd9), 0);
      set_w(1, 5'(i), {$urandom, $urandom} | 64'd1);
      cycle();
    end
    set_w(0, 5'd0, 64'd0);
    set_d(1, enc_r(5'd2, 5'd3, 5'd4), 0);
    cycle();
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid_E", 64'(valid_E), 64'd0);
    chk("arst_pc_E", pc_E, 64'd0);
    chk("arst_rd1_E", readData1_E, 64'd0);
    chk("arst_rd_E", 64'(rd_E), 64'd0);
    chk("arst_stall_D", 64'(stall_D), 64'd0);
    set_d(0, 32'd0, 0);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i < 8; i++) begin
      set_d(1, enc_r(5'(i), 5'(i), 5'd9), 0);
      cycle();
      chk("post_reset_reg", readData1_E, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
